// File: rtl/sys_reset_seq_if.sv
// sys_reset_seq_if
//  Bundles the lock/reset control signals of the reset sequencer.
//  master : the side driving lock status and requests (clock select / register block)
//  slave  : the reset sequencer itself
//  Signals:
//   locked        clock-good indication, asynchronous to sys_clock
//   soft_rst_req  1-cycle software reset request
//   clr_status    1-cycle clear of lock_lost / loss_count
//   core_resetn   active-low reset to core and peripherals
//   clk_ready     high only while the core is running
//   lock_lost     sticky lock-drop flag
//   loss_count    saturating lock-drop counter
//   state         sequencer state (debug)
interface sys_reset_seq_if #(
  parameter int LOSS_CW = 8
);
  logic               locked;
  logic               soft_rst_req;
  logic               clr_status;
  logic               core_resetn;
  logic               clk_ready;
  logic               lock_lost;
  logic [LOSS_CW-1:0] loss_count;
  logic [2:0]         state;

  modport master (
    output locked, soft_rst_req, clr_status,
    input  core_resetn, clk_ready, lock_lost, loss_count, state
  );

  modport slave (
    input  locked, soft_rst_req, clr_status,
    output core_resetn, clk_ready, lock_lost, loss_count, state
  );
endinterface

// File: rtl/sys_reset_seq.sv
// sys_reset_seq
//  Reset sequencer on the selected sys_clock. Synchronizes the async 'locked'
//  indication, requires it to stay high for LOCK_FILTER cycles, holds core
//  reset for HOLD_CYCLES more, then releases core_resetn. Lock drops while the
//  core is up (or in a soft reset) are recorded in a sticky flag and a
//  saturating counter. A software request pulses core_resetn low SOFT_CYCLES.
//  Ports:
//   sys_clock  single clock
//   resetn     async active-low reset (assert immediate, release expected
//              synchronous to sys_clock from upstream)
//   bus        sys_reset_seq_if.slave: locked/soft_rst_req/clr_status in,
//              core_resetn/clk_ready/lock_lost/loss_count/state out
module sys_reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 8,
  parameter int HOLD_CYCLES = 1024,
  parameter int SOFT_CYCLES = 16,
  parameter int LOSS_CW     = 8
) (
  input  logic             sys_clock,
  input  logic             resetn,
  sys_reset_seq_if.slave   bus
);

  localparam int MAX_AB = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_AB > SOFT_CYCLES) ? MAX_AB : SOFT_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_SOFT   = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   loss_ev;
  logic                   lost_q, lost_d;
  logic [LOSS_CW-1:0]     loss_q, loss_d;
  logic                   core_resetn_q;
  logic                   clk_ready_q;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Next-state / counter. cnt is reset on every state change, so the
  // terminal compares below are all relative to the entry of the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_ev = 1'b0;
    case (state_q)
      S_INIT: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (!locked_s) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(LOCK_FILTER - 1)) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STABLE: begin
        // A drop here is still part of bring-up, so it is not a loss event.
        if (!locked_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        // Lock loss has priority over a coincident soft request.
        if (!locked_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          loss_ev = 1'b1;
        end else if (bus.soft_rst_req) begin
          state_d = S_SOFT;
          cnt_d   = '0;
        end
      end
      S_SOFT: begin
        if (!locked_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          loss_ev = 1'b1;
        end else if (cnt_q == CW'(SOFT_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Status: an event wins over a same-cycle clear, but the clear still
  // drops the history, leaving a count of exactly one.
  always_comb begin
    lost_d = lost_q;
    loss_d = loss_q;
    if (loss_ev) begin
      lost_d = 1'b1;
      if (bus.clr_status)
        loss_d = LOSS_CW'(1);
      else if (loss_q != {LOSS_CW{1'b1}})
        loss_d = loss_q + LOSS_CW'(1);
    end else if (bus.clr_status) begin
      lost_d = 1'b0;
      loss_d = '0;
    end
  end

  // Outputs are decoded from next-state so they change on the same edge
  // as the state register.
  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      sync_q        <= '0;
      state_q       <= S_INIT;
      cnt_q         <= '0;
      core_resetn_q <= 1'b0;
      clk_ready_q   <= 1'b0;
      lost_q        <= 1'b0;
      loss_q        <= '0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], bus.locked};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      core_resetn_q <= (state_d == S_RUN);
      clk_ready_q   <= (state_d == S_RUN);
      lost_q        <= lost_d;
      loss_q        <= loss_d;
    end
  end

  assign bus.core_resetn = core_resetn_q;
  assign bus.clk_ready   = clk_ready_q;
  assign bus.lock_lost   = lost_q;
  assign bus.loss_count  = loss_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_sys_reset_seq.sv
// tb_sys_reset_seq
//  Directed sequences plus randomized lock/soft/clear stimulus. A timeline
//  model (elapsed edges since entering each phase) predicts every output on
//  every falling edge; literal checks pin the key latencies.
module tb_sys_reset_seq;
  localparam int SS = 2, LF = 4, HC = 16, SC = 5, LW = 2;
  localparam int MAXL = (1 << LW) - 1;
  localparam int M_INIT = 0, M_WAIT = 1, M_STABLE = 2, M_RUN = 3, M_SOFT = 4;

  logic sys_clock = 1'b0;
  logic resetn    = 1'b1;

  sys_reset_seq_if #(.LOSS_CW(LW)) bus();

  sys_reset_seq #(
    .SYNC_STAGES(SS), .LOCK_FILTER(LF), .HOLD_CYCLES(HC),
    .SOFT_CYCLES(SC), .LOSS_CW(LW)
  ) dut (
    .sys_clock(sys_clock),
    .resetn   (resetn),
    .bus      (bus)
  );

  always #5 sys_clock = ~sys_clock;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          mode   = M_INIT;
  int          t0     = 0;
  int          streak = 0;
  int          ec     = 0;
  int          mcnt   = 0;
  bit          mlost  = 1'b0;
  logic [SS-1:0] msh  = '0;
  bit          lsv, loss;

  always @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      mode = M_INIT; t0 = 0; streak = 0; ec = 0; mcnt = 0; mlost = 1'b0; msh = '0;
    end else begin
      ec++;
      lsv  = msh[SS-1];
      msh  = {msh[SS-2:0], bus.locked};
      loss = 1'b0;
      case (mode)
        M_INIT: begin mode = M_WAIT; streak = 0; end
        M_WAIT: begin
          streak = lsv ? streak + 1 : 0;
          if (streak == LF) begin mode = M_STABLE; t0 = ec; end
        end
        M_STABLE: begin
          if (!lsv) begin mode = M_WAIT; streak = 0; end
          else if (ec - t0 == HC) mode = M_RUN;
        end
        M_RUN: begin
          if (!lsv) begin mode = M_WAIT; streak = 0; loss = 1'b1; end
          else if (bus.soft_rst_req) begin mode = M_SOFT; t0 = ec; end
        end
        M_SOFT: begin
          if (!lsv) begin mode = M_WAIT; streak = 0; loss = 1'b1; end
          else if (ec - t0 == SC) mode = M_RUN;
        end
        default: mode = M_INIT;
      endcase
      if (loss) begin
        mlost = 1'b1;
        mcnt  = bus.clr_status ? 1 : ((mcnt + 1 > MAXL) ? MAXL : mcnt + 1);
      end else if (bus.clr_status) begin
        mlost = 1'b0;
        mcnt  = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge sys_clock) begin
    if (chk_on) begin
      check("core_resetn", 32'(bus.core_resetn), 32'(mode == M_RUN));
      check("clk_ready",   32'(bus.clk_ready),   32'(mode == M_RUN));
      check("state",       32'(bus.state),       32'(mode));
      check("lock_lost",   32'(bus.lock_lost),   32'(mlost));
      check("loss_count",  32'(bus.loss_count),  32'(mcnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic lose_relock();
    bus.locked = 1'b0;
    repeat (3) tick();
    bus.locked = 1'b1;
    repeat (22) tick();
  endtask

  int hold;

  initial begin
    bus.locked = 1'b0; bus.soft_rst_req = 1'b0; bus.clr_status = 1'b0;
    #1 resetn = 1'b0;
    #1 chk_on = 1'b1;
    check("rst_core",  32'(bus.core_resetn), 32'd0);
    check("rst_state", 32'(bus.state),       32'd0);
    check("rst_count", 32'(bus.loss_count),  32'd0);

    // Bring-up with locked constant high: release at edge 22.
    bus.locked = 1'b1;
    repeat (2) tick();
    resetn = 1'b1;
    repeat (21) tick();
    check("t1_edge21_core", 32'(bus.core_resetn), 32'd0);
    tick();
    check("t1_edge22_core",  32'(bus.core_resetn), 32'd1);
    check("t1_edge22_ready", 32'(bus.clk_ready),   32'd1);
    check("t1_edge22_state", 32'(bus.state),       32'd3);

    // Lock loss in RUN: core_resetn falls at edge 3.
    bus.locked = 1'b0;
    tick(); tick();
    check("t3_edge2_core", 32'(bus.core_resetn), 32'd1);
    tick();
    check("t3_edge3_core",  32'(bus.core_resetn), 32'd0);
    check("t3_edge3_lost",  32'(bus.lock_lost),   32'd1);
    check("t3_edge3_count", 32'(bus.loss_count),  32'd1);
    bus.locked = 1'b1;
    repeat (21) tick();
    check("t3_relock21", 32'(bus.core_resetn), 32'd0);
    tick();
    check("t3_relock22", 32'(bus.core_resetn), 32'd1);

    // Saturation, then clear coinciding with a loss.
    bus.clr_status = 1'b1; tick(); bus.clr_status = 1'b0;
    check("t4_clr_count", 32'(bus.loss_count), 32'd0);
    check("t4_clr_lost",  32'(bus.lock_lost),  32'd0);
    repeat (4) lose_relock();
    check("t4_sat_count", 32'(bus.loss_count), 32'd3);
    check("t4_sat_state", 32'(bus.state),      32'd3);
    bus.locked = 1'b0;
    tick(); tick();
    bus.clr_status = 1'b1; tick(); bus.clr_status = 1'b0;
    check("t4_clrev_count", 32'(bus.loss_count), 32'd1);
    check("t4_clrev_lost",  32'(bus.lock_lost),  32'd1);
    check("t4_clrev_state", 32'(bus.state),      32'd1);
    bus.locked = 1'b1;
    repeat (22) tick();
    check("t4_rerun", 32'(bus.state), 32'd3);

    // Soft reset: low exactly 5 cycles, no loss.
    bus.clr_status = 1'b1; tick(); bus.clr_status = 1'b0;
    bus.soft_rst_req = 1'b1; tick(); bus.soft_rst_req = 1'b0;
    check("t5_soft_state", 32'(bus.state), 32'd4);
    check("t5_soft_core0", 32'(bus.core_resetn), 32'd0);
    for (int i = 1; i < 5; i++) begin
      tick();
      check("t5_soft_core_low", 32'(bus.core_resetn), 32'd0);
    end
    tick();
    check("t5_soft_back_core",  32'(bus.core_resetn), 32'd1);
    check("t5_soft_back_state", 32'(bus.state),       32'd3);
    check("t5_soft_no_loss",    32'(bus.loss_count),  32'd0);
    // Soft request on the edge that sees the drop.
    bus.locked = 1'b0;
    tick(); tick();
    bus.soft_rst_req = 1'b1; tick(); bus.soft_rst_req = 1'b0;
    check("t5_both_state", 32'(bus.state),      32'd1);
    check("t5_both_count", 32'(bus.loss_count), 32'd1);
    bus.locked = 1'b1;
    repeat (22) tick();
    check("t5_rerun", 32'(bus.state), 32'd3);

    // Async reset mid-STABLE takes effect without a clock edge.
    lose_relock();
    bus.locked = 1'b0;
    repeat (3) tick();
    bus.locked = 1'b1;
    repeat (10) tick();
    check("t6_in_stable", 32'(bus.state), 32'd2);
    #1 resetn = 1'b0;
    #1;
    check("t6_async_core",  32'(bus.core_resetn), 32'd0);
    check("t6_async_ready", 32'(bus.clk_ready),   32'd0);
    check("t6_async_state", 32'(bus.state),       32'd0);
    check("t6_async_lost",  32'(bus.lock_lost),   32'd0);
    check("t6_async_count", 32'(bus.loss_count),  32'd0);
    tick(); tick();
    resetn = 1'b1;
    repeat (21) tick();
    check("t6_edge21_core", 32'(bus.core_resetn), 32'd0);
    tick();
    check("t6_edge22_core", 32'(bus.core_resetn), 32'd1);

    // Glitchy lock: 3 high / 1 low never passes the filter.
    resetn = 1'b0; bus.locked = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bus.locked = ((k % 4) != 3);
      tick();
    end
    check("t2_state", 32'(bus.state),       32'd1);
    check("t2_core",  32'(bus.core_resetn), 32'd0);
    check("t2_count", 32'(bus.loss_count),  32'd0);

    // Randomized lock / soft / clear traffic against the model.
    bus.locked = 1'b1;
    hold = 40;
    for (int k = 0; k < 6000; k++) begin
      if (hold == 0) begin
        bus.locked = ~bus.locked;
        hold = bus.locked ? $urandom_range(1, 80) : $urandom_range(1, 6);
      end else begin
        hold--;
      end
      bus.soft_rst_req = ($urandom_range(0, 19) == 0);
      bus.clr_status   = ($urandom_range(0, 39) == 0);
      tick();
    end
    bus.soft_rst_req = 1'b0; bus.clr_status = 1'b0;
    tick();

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
